// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the SRAM-like responder: size encodings, depth limit
// and the layout of one pending-response entry.
package sram_like_defs;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam int MAX_DEPTH = 4;
  localparam int WAIT_W    = 8;

  typedef struct packed {
    logic              is_rd;
    logic [31:0]       data;
    logic [WAIT_W-1:0] wait_cnt;
  } resp_entry_t;

  localparam int ENTRY_W = $bits(resp_entry_t);

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: per-entry latency countdown, head pop and the
// registered data_ok/rdata pair presented to the master.
module sram_like_resp_fifo
  import sram_like_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push_i,
  input  resp_entry_t entry_i,
  output logic        full_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o
);

  localparam int CNT_W = $clog2(MAX_DEPTH + 1);

  resp_entry_t      ent_q [DEPTH];
  resp_entry_t      ent_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wr_ptr;
  logic             data_ok_q, data_ok_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             pop;

  // data_ok_q is only ever set for a head whose countdown has expired, so the
  // cycle it is high is exactly the cycle that head leaves the queue.
  assign pop    = data_ok_q;
  assign full_o = (count_q == CNT_W'(DEPTH));

  // NOTE: every combinational output gets a default on entry so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q && ent_q[i].wait_cnt != '0) begin
        ent_d[i].wait_cnt = ent_q[i].wait_cnt - WAIT_W'(1);
      end
    end

    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        ent_d[i] = ent_d[i + 1];
      end
    end

    wr_ptr = count_q - CNT_W'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      if (push_i && CNT_W'(i) == wr_ptr) begin
        ent_d[i] = entry_i;
      end
    end
    count_d = wr_ptr + CNT_W'(push_i);

    // Outputs are registered from the next-state head so data_ok lands in
    // the very cycle the head's countdown reaches zero.
    data_ok_d = (count_d != '0) && (ent_d[0].wait_cnt == '0);
    rdata_d   = (data_ok_d && ent_d[0].is_rd) ? ent_d[0].data : 32'h0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q   <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      count_q   <= count_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  // Entry payloads need no reset: an entry is live only below count_q.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign data_ok_o = data_ok_q;
  assign rdata_o   = rdata_q;

endmodule

// File: rtl/sram_like_responder.sv
// Slave end of the req/addr_ok/data_ok SRAM-like bus: word memory with byte
// strobes, accept throttling (occupancy and address gap) and response queue.
module sram_like_responder
  import sram_like_defs::*;
#(
  parameter int AW       = 14,
  parameter int DEPTH    = 2,
  parameter int DATA_LAT = 1,
  parameter int ADDR_GAP = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int GAP_W = (ADDR_GAP > 0) ? $clog2(ADDR_GAP + 1) : 1;

  logic [31:0]   mem_q [0:(1 << AW) - 1];
  logic [AW-1:0] word_idx;
  logic          resetn_q;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic          fifo_full;
  logic          push;
  resp_entry_t   push_entry;

  // Size and the byte offset / aliased upper address bits do not affect the access.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

  assign word_idx = addr[AW+1:2];

  // resetn gates directly so nothing is accepted during the reset cycle itself;
  // resetn_q keeps addr_ok low for one more cycle after release.
  assign addr_ok = resetn & resetn_q & req & ~fifo_full & (gap_cnt_q == '0);
  assign push    = addr_ok;

  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (push) begin
      gap_cnt_d = GAP_W'(ADDR_GAP);
    end else if (gap_cnt_q != '0) begin
      gap_cnt_d = gap_cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    resetn_q <= resetn;
    if (!resetn) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // NOTE: the memory array is deliberately left out of reset; contents must
  // survive a reset, and a reset port would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data is captured at accept, so later writes cannot disturb it.
  always_comb begin
    push_entry.is_rd    = ~wr;
    push_entry.data     = mem_q[word_idx];
    push_entry.wait_cnt = WAIT_W'(DATA_LAT - 1);
  end

  sram_like_resp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push_i   (push),
    .entry_i  (push_entry),
    .full_o   (fifo_full),
    .data_ok_o(data_ok),
    .rdata_o  (rdata)
  );

endmodule
